// File: rtl/audio_mixer_nch_pkg.sv
// Shared CSR map, bit positions and saturation helpers for the N-channel audio mixer.
package audio_mixer_pkg;
    localparam int ADDR_CTRL      = 0;
    localparam int ADDR_STATUS    = 1;
    localparam int ADDR_PEAK      = 2;
    localparam int ADDR_GAIN_BASE = 4;

    localparam int CTRL_ENABLE_BIT    = 0;
    localparam int CTRL_MUTE_BIT      = 1;
    localparam int STATUS_CLIP_W      = 16;
    localparam int STATUS_PKT_ERR_BIT = 16;

    // Clamp a signed value (held in 64 bits) to the range of a w-bit signed number.
    function automatic logic signed [63:0] sat_value(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

    function automatic logic is_sat(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (x > hi) || (x < lo);
    endfunction
endpackage

// File: rtl/audio_mixer_nch_if.sv
// Stream-in, stream-out and CSR bus bundle for audio_mixer_nch.
interface audio_mixer_nch_if #(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 24,
    parameter int ADDR_W   = 3
) ();
    logic [NUM_CH*SAMPLE_W-1:0] d_data;
    logic [NUM_CH-1:0]          d_data_valid;
    logic [NUM_CH-1:0]          d_ready;
    logic [NUM_CH-1:0]          d_start_packet;
    logic [NUM_CH-1:0]          d_end_packet;
    logic [SAMPLE_W-1:0]        s_data;
    logic                       s_data_valid;
    logic                       s_ready;
    logic                       s_start_packet;
    logic                       s_end_packet;
    logic [ADDR_W-1:0]          iCSR_ADDRESS;
    logic                       iCSR_READ;
    logic [31:0]                oCSR_READ_DATA;
    logic                       iCSR_WRITE;
    logic [31:0]                iCSR_WRITE_DATA;

    modport slave (
        input  d_data, d_data_valid, d_start_packet, d_end_packet,
        output d_ready,
        output s_data, s_data_valid, s_start_packet, s_end_packet,
        input  s_ready,
        input  iCSR_ADDRESS, iCSR_READ, iCSR_WRITE, iCSR_WRITE_DATA,
        output oCSR_READ_DATA
    );

    modport master (
        output d_data, d_data_valid, d_start_packet, d_end_packet,
        input  d_ready,
        input  s_data, s_data_valid, s_start_packet, s_end_packet,
        output s_ready,
        output iCSR_ADDRESS, iCSR_READ, iCSR_WRITE, iCSR_WRITE_DATA,
        input  oCSR_READ_DATA
    );
endinterface

// File: rtl/audio_mixer_nch_csr.sv
// CSR register file: CTRL, STATUS (clip count, pkt_err), per-channel gains, registered read mux.
// Peak tracking on address 2 is built only when AUDIO_MIXER_NCH_PEAK_EN is defined.
module audio_mixer_csr
    import audio_mixer_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 24,
    parameter int GAIN_W   = 16,
    parameter int ADDR_W   = 3
) (
    input  logic                     iCLOCK,
    input  logic                     iRESET,
    input  logic [ADDR_W-1:0]        i_csr_address,
    input  logic                     i_csr_read,
    input  logic                     i_csr_write,
    input  logic [31:0]              i_csr_write_data,
    output logic [31:0]              o_csr_read_data,
    output logic                     o_enable,
    output logic                     o_mute,
    output logic [NUM_CH*GAIN_W-1:0] o_gains,
`ifdef AUDIO_MIXER_NCH_PEAK_EN
    input  logic                     i_peak_evt,
    input  logic [SAMPLE_W-1:0]      i_peak_data,
`endif
    input  logic                     i_clip_evt,
    input  logic                     i_pkt_err_evt
);
    localparam logic [GAIN_W-1:0] GAIN_UNITY = {2'b01, {(GAIN_W-2){1'b0}}};

    logic                     r_enable;
    logic                     r_mute;
    logic [STATUS_CLIP_W-1:0] r_clip;
    logic                     r_pkt_err;
    logic [31:0]              r_rdata;
    logic [31:0]              w_rd;
    logic [NUM_CH*GAIN_W-1:0] w_gains;
    logic                     w_wr_ctrl;
    logic                     w_wr_status;

    assign w_wr_ctrl   = i_csr_write && (i_csr_address == ADDR_W'(ADDR_CTRL));
    assign w_wr_status = i_csr_write && (i_csr_address == ADDR_W'(ADDR_STATUS));

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            r_enable <= 1'b1;
            r_mute   <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_enable <= i_csr_write_data[CTRL_ENABLE_BIT];
            r_mute   <= i_csr_write_data[CTRL_MUTE_BIT];
        end
    end

    // A STATUS write wins over a clip/pkt_err event in the same cycle.
    always_ff @(posedge iCLOCK) begin
        if (iRESET || w_wr_status) begin
            r_clip    <= '0;
            r_pkt_err <= 1'b0;
        end else begin
            if (i_clip_evt && (r_clip != {STATUS_CLIP_W{1'b1}}))
                r_clip <= r_clip + 1'b1;
            if (i_pkt_err_evt)
                r_pkt_err <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_gain
            logic [GAIN_W-1:0] r_gain;
            always_ff @(posedge iCLOCK) begin
                if (iRESET)
                    r_gain <= GAIN_UNITY;
                else if (i_csr_write && (i_csr_address == ADDR_W'(ADDR_GAIN_BASE + gi)))
                    r_gain <= i_csr_write_data[GAIN_W-1:0];
            end
            assign w_gains[gi*GAIN_W +: GAIN_W] = r_gain;
        end
    endgenerate

`ifdef AUDIO_MIXER_NCH_PEAK_EN
    logic [SAMPLE_W-1:0] r_peak;
    logic [SAMPLE_W-1:0] w_abs;
    logic                w_rd_peak;

    assign w_rd_peak = i_csr_read && (i_csr_address == ADDR_W'(ADDR_PEAK));

    always_comb begin
        w_abs = i_peak_data;
        if (i_peak_data == {1'b1, {(SAMPLE_W-1){1'b0}}})
            w_abs = {1'b0, {(SAMPLE_W-1){1'b1}}};
        else if (i_peak_data[SAMPLE_W-1])
            w_abs = -i_peak_data;
    end

    // An output landing on the read cycle seeds the next window.
    always_ff @(posedge iCLOCK) begin
        if (iRESET)
            r_peak <= '0;
        else if (w_rd_peak)
            r_peak <= i_peak_evt ? w_abs : '0;
        else if (i_peak_evt && (w_abs > r_peak))
            r_peak <= w_abs;
    end
`endif

    always_comb begin
        w_rd = '0;
        if (i_csr_address == ADDR_W'(ADDR_CTRL)) begin
            w_rd[CTRL_ENABLE_BIT] = r_enable;
            w_rd[CTRL_MUTE_BIT]   = r_mute;
        end
        if (i_csr_address == ADDR_W'(ADDR_STATUS)) begin
            w_rd[STATUS_CLIP_W-1:0]    = r_clip;
            w_rd[STATUS_PKT_ERR_BIT]   = r_pkt_err;
        end
`ifdef AUDIO_MIXER_NCH_PEAK_EN
        if (i_csr_address == ADDR_W'(ADDR_PEAK))
            w_rd = 32'(r_peak);
`endif
        for (int k = 0; k < NUM_CH; k++) begin
            if (i_csr_address == ADDR_W'(ADDR_GAIN_BASE + k))
                w_rd = 32'($signed(w_gains[k*GAIN_W +: GAIN_W]));
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET)
            r_rdata <= '0;
        else if (i_csr_read)
            r_rdata <= w_rd;
    end

    assign o_csr_read_data = r_rdata;
    assign o_enable        = r_enable;
    assign o_mute          = r_mute;
    assign o_gains         = w_gains;
endmodule

// File: rtl/audio_mixer_nch.sv
// N-channel mixer: lock-step join, per-channel gain (stage A), sum/saturate/mute (stage B).
// Optional peak meter on CSR address 2 when AUDIO_MIXER_NCH_PEAK_EN is defined.
module audio_mixer_nch
    import audio_mixer_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 24,
    parameter int GAIN_W   = 16,
    parameter int ADDR_W   = 3
) (
    input  logic              iCLOCK,
    input  logic              iRESET,
    audio_mixer_nch_if.slave  bus
);
    localparam int PW    = SAMPLE_W + GAIN_W;
    localparam int SW    = PW + $clog2(NUM_CH);
    localparam int SHIFT = GAIN_W - 2;

    logic                      w_enable;
    logic                      w_mute;
    logic [NUM_CH*GAIN_W-1:0]  w_gains;
    logic                      w_advance;
    logic                      w_accept;
    logic                      w_pkt_err_evt;
    logic [NUM_CH*PW-1:0]      w_prod_q;
    logic signed [SW-1:0]      w_sum;
    logic [SAMPLE_W-1:0]       w_sat_data;
    logic [SAMPLE_W-1:0]       w_b_data;
    logic                      w_clip;
    logic                      w_b_load;
    logic                      r_a_valid;
    logic                      r_a_sop;
    logic                      r_a_eop;
    logic                      r_s_valid;
    logic                      r_s_sop;
    logic                      r_s_eop;
    logic [SAMPLE_W-1:0]       r_s_data;

    assign w_advance   = !r_s_valid || bus.s_ready;
    assign w_accept    = w_enable && (&bus.d_data_valid) && w_advance;
    assign bus.d_ready = {NUM_CH{w_accept}};

    assign w_pkt_err_evt = w_accept &&
        (((|bus.d_start_packet) && !(&bus.d_start_packet)) ||
         ((|bus.d_end_packet)   && !(&bus.d_end_packet)));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
            logic signed [SAMPLE_W-1:0] w_sample;
            logic signed [GAIN_W-1:0]   w_gain;
            logic signed [PW-1:0]       w_prod;
            logic signed [PW-1:0]       r_prod;
            assign w_sample = bus.d_data[gi*SAMPLE_W +: SAMPLE_W];
            assign w_gain   = w_gains[gi*GAIN_W +: GAIN_W];
            assign w_prod   = (PW'(w_sample) * PW'(w_gain)) >>> SHIFT;
            always_ff @(posedge iCLOCK) begin
                if (iRESET)
                    r_prod <= '0;
                else if (w_accept)
                    r_prod <= w_prod;
            end
            assign w_prod_q[gi*PW +: PW] = r_prod;
        end
    endgenerate

    // Stage A only moves when B can take its contents, so A+B hold two samples under stall.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            r_a_valid <= 1'b0;
            r_a_sop   <= 1'b0;
            r_a_eop   <= 1'b0;
        end else if (w_advance) begin
            r_a_valid <= w_accept;
            if (w_accept) begin
                r_a_sop <= bus.d_start_packet[0];
                r_a_eop <= bus.d_end_packet[0];
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NUM_CH; k++)
            w_sum = w_sum + SW'($signed(w_prod_q[k*PW +: PW]));
    end

    assign w_sat_data = SAMPLE_W'(sat_value(64'(w_sum), SAMPLE_W));
    assign w_clip     = is_sat(64'(w_sum), SAMPLE_W);
    assign w_b_data   = w_mute ? '0 : w_sat_data;
    assign w_b_load   = w_advance && r_a_valid;

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
            r_s_sop   <= 1'b0;
            r_s_eop   <= 1'b0;
        end else if (w_advance) begin
            r_s_valid <= r_a_valid;
            if (r_a_valid) begin
                r_s_data <= w_b_data;
                r_s_sop  <= r_a_sop;
                r_s_eop  <= r_a_eop;
            end
        end
    end

    assign bus.s_data         = r_s_data;
    assign bus.s_data_valid   = r_s_valid;
    assign bus.s_start_packet = r_s_sop;
    assign bus.s_end_packet   = r_s_eop;

    audio_mixer_csr #(
        .NUM_CH   (NUM_CH),
        .SAMPLE_W (SAMPLE_W),
        .GAIN_W   (GAIN_W),
        .ADDR_W   (ADDR_W)
    ) u_csr (
        .iCLOCK           (iCLOCK),
        .iRESET           (iRESET),
        .i_csr_address    (bus.iCSR_ADDRESS),
        .i_csr_read       (bus.iCSR_READ),
        .i_csr_write      (bus.iCSR_WRITE),
        .i_csr_write_data (bus.iCSR_WRITE_DATA),
        .o_csr_read_data  (bus.oCSR_READ_DATA),
        .o_enable         (w_enable),
        .o_mute           (w_mute),
        .o_gains          (w_gains),
`ifdef AUDIO_MIXER_NCH_PEAK_EN
        .i_peak_evt       (w_b_load),
        .i_peak_data      (w_b_data),
`endif
        .i_clip_evt       (w_b_load && w_clip),
        .i_pkt_err_evt    (w_pkt_err_evt)
    );
endmodule

// File: tb/tb_audio_mixer_nch.sv
// Directed testbench for audio_mixer_nch (NUM_CH=4, SAMPLE_W=24, GAIN_W=16).
module tb_audio_mixer_nch;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    audio_mixer_nch_if #(.NUM_CH(4), .SAMPLE_W(24), .ADDR_W(3)) bus ();

    audio_mixer_nch #(.NUM_CH(4), .SAMPLE_W(24), .GAIN_W(16), .ADDR_W(3)) dut (
        .iCLOCK (clk),
        .iRESET (rst),
        .bus    (bus)
    );

    task automatic drive(input int c0, input int c1, input int c2, input int c3,
                         input logic [3:0] v, input logic [3:0] sop, input logic [3:0] eop);
        bus.d_data         = {24'(c3), 24'(c2), 24'(c1), 24'(c0)};
        bus.d_data_valid   = v;
        bus.d_start_packet = sop;
        bus.d_end_packet   = eop;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    endtask

    // One sample on all channels; returns at the negedge right after the accepting edge.
    task automatic send(input int c0, input int c1, input int c2, input int c3,
                        input logic [3:0] sop, input logic [3:0] eop);
        @(negedge clk);
        drive(c0, c1, c2, c3, 4'hF, sop, eop);
        @(negedge clk);
        idle();
    endtask

    task automatic csr_write(input int addr, input logic [31:0] data);
        @(negedge clk);
        bus.iCSR_ADDRESS    = 3'(addr);
        bus.iCSR_WRITE_DATA = data;
        bus.iCSR_WRITE      = 1'b1;
        @(negedge clk);
        bus.iCSR_WRITE      = 1'b0;
    endtask

    task automatic csr_read(input int addr, output logic [31:0] data);
        @(negedge clk);
        bus.iCSR_ADDRESS = 3'(addr);
        bus.iCSR_READ    = 1'b1;
        @(negedge clk);
        bus.iCSR_READ    = 1'b0;
        #1 data = bus.oCSR_READ_DATA;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (bus.s_data_valid !== 1'b0 || bus.s_data !== 24'h0 || bus.s_start_packet !== 1'b0 ||
            bus.s_end_packet !== 1'b0 || bus.oCSR_READ_DATA !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b data=%h sop=%b eop=%b rd=%h, required all 0",
                     bus.s_data_valid, bus.s_data, bus.s_start_packet, bus.s_end_packet, bus.oCSR_READ_DATA);
        end
        rst = 1'b0;
        csr_read(0, rd);
        total++;
        if (rd !== 32'h1) begin bad++; $display("FAIL reset_ctrl: got %h required 00000001", rd); end
        csr_read(1, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL reset_status: got %h required 00000000", rd); end
        csr_read(4, rd);
        total++;
        if (rd !== 32'h4000) begin bad++; $display("FAIL reset_gain0: got %h required 00004000", rd); end
        csr_read(7, rd);
        total++;
        if (rd !== 32'h4000) begin bad++; $display("FAIL reset_gain3: got %h required 00004000", rd); end
        csr_read(3, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL reserved_addr3: got %h required 00000000", rd); end
        $display("reset: done");
    endtask

    task automatic test_basic();
        @(negedge clk);
        drive(100, 200, -50, 0, 4'hF, 4'hF, 4'hF);
        #1;
        total++;
        if (bus.d_ready !== 4'hF) begin bad++; $display("FAIL basic_ready: got %b required 1111", bus.d_ready); end
        @(negedge clk);
        idle();
        #1;
        total++;
        if (bus.s_data_valid !== 1'b0) begin bad++; $display("FAIL basic_latency1: valid=%b required 0", bus.s_data_valid); end
        @(negedge clk);
        #1;
        total++;
        if (bus.s_data_valid !== 1'b1 || bus.s_data !== 24'd250 || bus.s_start_packet !== 1'b1 ||
            bus.s_end_packet !== 1'b1) begin
            bad++;
            $display("FAIL basic_mix: valid=%b data=%0d sop=%b eop=%b, required 1 250 1 1",
                     bus.s_data_valid, bus.s_data, bus.s_start_packet, bus.s_end_packet);
        end
        $display("basic: 100+200-50+0 -> %0d", bus.s_data);
    endtask

    task automatic test_join_stall();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1, 2, 3, 4, 4'b1011, 4'h0, 4'h0);
            #1;
            total++;
            if (bus.d_ready !== 4'h0 || bus.s_data_valid !== 1'b0) begin
                bad++;
                $display("FAIL join_hold: cycle %0d ready=%b valid=%b, required 0000 0", i, bus.d_ready, bus.s_data_valid);
            end
        end
        @(negedge clk);
        drive(1, 2, 3, 4, 4'hF, 4'h0, 4'h0);
        #1;
        total++;
        if (bus.d_ready !== 4'hF) begin bad++; $display("FAIL join_ready: got %b required 1111", bus.d_ready); end
        @(negedge clk);
        idle();
        @(negedge clk);
        #1;
        total++;
        if (bus.s_data_valid !== 1'b1 || bus.s_data !== 24'd10) begin
            bad++;
            $display("FAIL join_mix: valid=%b data=%0d required 1 10", bus.s_data_valid, bus.s_data);
        end
        @(negedge clk);
        #1;
        total++;
        if (bus.s_data_valid !== 1'b0) begin bad++; $display("FAIL join_single: valid=%b required 0", bus.s_data_valid); end
        $display("join: one sample after stall");
    endtask

    task automatic test_clip();
        logic [31:0] rd;
        send(32'h7FFFFF, 32'h7FFFFF, 32'h7FFFFF, 32'h7FFFFF, 4'h0, 4'h0);
        @(negedge clk);
        #1;
        total++;
        if (bus.s_data_valid !== 1'b1 || bus.s_data !== 24'h7FFFFF) begin
            bad++;
            $display("FAIL clip_data: valid=%b data=%h required 1 7fffff", bus.s_data_valid, bus.s_data);
        end
        csr_read(1, rd);
        total++;
        if (rd !== 32'h1) begin bad++; $display("FAIL clip_count: got %h required 00000001", rd); end
        csr_write(1, 32'h0);
        csr_read(1, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL clip_clear: got %h required 00000000", rd); end
        $display("clip: saturated and cleared");
    endtask

    task automatic test_gain();
        logic [31:0] rd;
        csr_write(5, 32'h2000);
        csr_write(6, 32'hC000);
        csr_read(6, rd);
        total++;
        if (rd !== 32'hFFFFC000) begin bad++; $display("FAIL gain_readback: got %h required ffffc000", rd); end
        send(0, 1001, 0, 0, 4'h0, 4'h0);
        @(negedge clk);
        #1;
        total++;
        if (bus.s_data !== 24'd500) begin bad++; $display("FAIL gain_half_pos: got %0d required 500", bus.s_data); end
        send(0, -1001, 0, 0, 4'h0, 4'h0);
        @(negedge clk);
        #1;
        total++;
        if (bus.s_data !== 24'hFFFE0B) begin bad++; $display("FAIL gain_half_neg: got %h required fffe0b (-501)", bus.s_data); end
        send(0, 0, 7, 0, 4'h0, 4'h0);
        @(negedge clk);
        #1;
        total++;
        if (bus.s_data !== 24'hFFFFF9) begin bad++; $display("FAIL gain_neg_unity: got %h required fffff9 (-7)", bus.s_data); end
        csr_write(5, 32'h4000);
        csr_write(6, 32'h4000);
        $display("gain: 0.5 and -1.0 applied");
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 3) drive(0, 0, 0, c + 1, 4'hF, 4'h0, 4'h0);
            else       idle();
            #1;
            if (c >= 2 && c <= 4) begin
                total++;
                if (bus.s_data_valid !== 1'b1 || bus.s_data !== 24'(c - 1)) begin
                    bad++;
                    $display("FAIL b2b_out: cycle %0d valid=%b data=%0d required 1 %0d", c, bus.s_data_valid, bus.s_data, c - 1);
                end
            end else if (c == 5) begin
                total++;
                if (bus.s_data_valid !== 1'b0) begin bad++; $display("FAIL b2b_end: valid=%b required 0", bus.s_data_valid); end
            end
        end
        $display("back_to_back: 3 samples in consecutive cycles");
    endtask

    task automatic test_backpressure();
        int n = 0;
        int got = 0;
        bus.s_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drive(10 + n, 0, 0, 0, 4'hF, 4'h0, 4'h0);
            #1;
            if (bus.d_ready === 4'hF) n++;
            if (c >= 2) begin
                total++;
                if (bus.s_data_valid !== 1'b1 || bus.s_data !== 24'd10) begin
                    bad++;
                    $display("FAIL bp_hold: cycle %0d valid=%b data=%0d required 1 10", c, bus.s_data_valid, bus.s_data);
                end
            end
        end
        total++;
        if (n != 2) begin bad++; $display("FAIL bp_buffered: accepted %0d required 2", n); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            idle();
            bus.s_ready = 1'b1;
            #1;
            if (bus.s_data_valid === 1'b1) begin
                total++;
                if (bus.s_data !== 24'(10 + got)) begin
                    bad++;
                    $display("FAIL bp_order: got %0d required %0d", bus.s_data, 10 + got);
                end
                got++;
            end
        end
        total++;
        if (got != 2) begin bad++; $display("FAIL bp_drain: outputs %0d required 2", got); end
        $display("backpressure: %0d buffered, %0d drained", n, got);
    endtask

    task automatic test_enable_mute();
        logic [31:0] rd;
        csr_write(0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(5, 0, 0, 0, 4'hF, 4'h0, 4'h0);
            #1;
            total++;
            if (bus.d_ready !== 4'h0) begin bad++; $display("FAIL disable_ready: got %b required 0000", bus.d_ready); end
        end
        idle();
        csr_write(0, 32'h3);
        send(5, 0, 0, 0, 4'h0, 4'h0);
        @(negedge clk);
        #1;
        total++;
        if (bus.s_data_valid !== 1'b1 || bus.s_data !== 24'd0) begin
            bad++;
            $display("FAIL mute_data: valid=%b data=%0d required 1 0", bus.s_data_valid, bus.s_data);
        end
        csr_write(0, 32'h1);
        csr_read(0, rd);
        total++;
        if (rd !== 32'h1) begin bad++; $display("FAIL ctrl_restore: got %h required 00000001", rd); end
        $display("enable_mute: disable blocks, mute zeroes");
    endtask

    task automatic test_pkt_peak();
        logic [31:0] rd;
        csr_read(2, rd);
        send(-100, -200, 0, 0, 4'b0111, 4'h0);
        @(negedge clk);
        #1;
        total++;
        if (bus.s_data !== 24'hFFFED4 || bus.s_start_packet !== 1'b1 || bus.s_end_packet !== 1'b0) begin
            bad++;
            $display("FAIL pkt_out: data=%h sop=%b eop=%b required fffed4 1 0", bus.s_data, bus.s_start_packet, bus.s_end_packet);
        end
        csr_read(1, rd);
        total++;
        if (rd !== 32'h10000) begin bad++; $display("FAIL pkt_err: status %h required 00010000", rd); end
`ifdef AUDIO_MIXER_NCH_PEAK_EN
        csr_read(2, rd);
        total++;
        if (rd !== 32'd300) begin bad++; $display("FAIL peak_value: got %0d required 300", rd); end
        csr_read(2, rd);
        total++;
        if (rd !== 32'd0) begin bad++; $display("FAIL peak_clear: got %0d required 0", rd); end
`else
        csr_read(2, rd);
        total++;
        if (rd !== 32'd0) begin bad++; $display("FAIL peak_absent: got %0d required 0", rd); end
`endif
        csr_write(1, 32'h0);
        $display("pkt_peak: mismatch flagged");
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        @(negedge clk);
        drive(9, 0, 0, 0, 4'hF, 4'h0, 4'h0);
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            total++;
            if (bus.s_data_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_discard: cycle %0d valid=%b required 0", c, bus.s_data_valid); end
        end
        csr_read(1, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL reset_mid_status: got %h required 00000000", rd); end
        $display("reset_mid: in-flight sample discarded");
    endtask

    initial begin
        rst                 = 1'b1;
        bus.s_ready         = 1'b1;
        bus.iCSR_ADDRESS    = '0;
        bus.iCSR_READ       = 1'b0;
        bus.iCSR_WRITE      = 1'b0;
        bus.iCSR_WRITE_DATA = '0;
        idle();
        test_reset();
        test_basic();
        test_join_stall();
        test_clip();
        test_gain();
        test_back_to_back();
        test_backpressure();
        test_enable_mute();
        test_pkt_peak();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
